// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetch PC, memory request handshake and a small prefetch queue
// feeding decode. Optional HLT detection is enabled by defining HALT_DETECT_EN.
module fetch_unit #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned QDEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              cmd_valid,
  output logic [15:0]       command,
  output logic [ADDR_W-1:0] cmd_pc,
  input  logic              cmd_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_halted
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] QDepthC = CntW'(QDEPTH);

  logic [ADDR_W-1:0] r_fpc;
  logic              r_run;
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [CntW-1:0]   r_count;
  logic [15:0]       r_q_data [QDEPTH];
  logic [ADDR_W-1:0] r_q_pc   [QDEPTH];

  logic              w_halted;
  logic              w_push;
  logic              w_pop;
  logic [CntW-1:0]   w_count_d;

  assign imem_req  = r_run && (r_count < QDepthC) && !w_halted;
  assign imem_addr = r_fpc;
  assign w_push    = imem_req && imem_ack;
  assign cmd_valid = (r_count != '0);
  assign w_pop     = cmd_valid && cmd_ready;
  assign command   = r_q_data[r_rptr];
  assign cmd_pc    = r_q_pc[r_rptr];
  assign fetch_halted = w_halted;

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + CntW'(1);
      2'b01:   w_count_d = r_count - CntW'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fpc   <= RESET_PC;
      r_run   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        r_q_data[i] <= '0;
        r_q_pc[i]   <= '0;
      end
    end else begin
      r_run <= 1'b1;
      // Redirect wins: flush and drop any word transferred this cycle.
      if (redirect) begin
        r_fpc   <= redirect_pc;
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_q_data[r_wptr] <= imem_rdata;
          r_q_pc[r_wptr]   <= r_fpc;
          r_wptr           <= r_wptr + PtrW'(1);
          r_fpc            <= r_fpc + ADDR_W'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PtrW'(1);
        end
        r_count <= w_count_d;
      end
    end
  end

`ifdef HALT_DETECT_EN
  logic r_halted;
  logic w_is_hlt;

  assign w_is_hlt = (imem_rdata[15:14] == 2'b11) && (imem_rdata[7:4] == 4'b1111);
  assign w_halted = r_halted;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_halted <= 1'b0;
    end else if (redirect) begin
      r_halted <= 1'b0;
    end else if (w_push && w_is_hlt) begin
      r_halted <= 1'b1;
    end
  end
`else
  assign w_halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: start-up, back-pressure, redirect, reset, PC wrap and HLT.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack, cmd_valid, cmd_ready, redirect, fetch_halted;
  logic [15:0] imem_addr, imem_rdata, command, cmd_pc, redirect_pc;
  logic        hlt_mem;

  logic        imem_req2, cmd_valid2, fetch_halted2;
  logic [15:0] imem_addr2, command2, cmd_pc2;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef HALT_DETECT_EN
  localparam logic HaltEn = 1'b1;
`else
  localparam logic HaltEn = 1'b0;
`endif

  always #5 clock = ~clock;

  assign imem_rdata = (hlt_mem && imem_addr == 16'd3) ? 16'hC0F0 : (16'hC000 | imem_addr);

  fetch_unit #(.ADDR_W(16), .QDEPTH(2), .RESET_PC(16'h0000)) u_dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .cmd_valid(cmd_valid), .command(command),
    .cmd_pc(cmd_pc), .cmd_ready(cmd_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_halted(fetch_halted)
  );

  // Second instance exercises PC wrap; its memory returns the address as data.
  fetch_unit #(.ADDR_W(16), .QDEPTH(2), .RESET_PC(16'hFFFF)) u_dut_wrap (
    .clock(clock), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(1'b1), .imem_rdata(imem_addr2), .cmd_valid(cmd_valid2), .command(command2),
    .cmd_pc(cmd_pc2), .cmd_ready(1'b1), .redirect(1'b0), .redirect_pc(16'h0000),
    .fetch_halted(fetch_halted2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b1; cmd_ready = 1'b1; redirect = 1'b0;
    redirect_pc = 16'h0000; hlt_mem = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_req", imem_req, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_cmd", command, 16'h0000);
    check("rst_pc", cmd_pc, 0);
    check("rst_halt", fetch_halted, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_addr2", imem_addr2, 16'hFFFF);
    reset = 1'b0;

    // First cycle after release: run set, first request
    step();
    check("t1_req", imem_req, 1);
    check("t1_addr", imem_addr, 0);
    check("t1_valid", cmd_valid, 0);
    check("t4_req", imem_req2, 1);
    check("t4_addr0", imem_addr2, 16'hFFFF);

    // Streaming at one word per cycle
    for (int k = 0; k < 4; k++) begin
      step();
      check("t1_valid_s", cmd_valid, 1);
      check("t1_cmd_s", command, 16'hC000 | 16'(k));
      check("t1_pc_s", cmd_pc, k);
      check("t1_addr_s", imem_addr, k + 1);
      if (k == 0) begin
        check("t4_pc_ffff", cmd_pc2, 16'hFFFF);
        check("t4_addr_wrap", imem_addr2, 16'h0000);
      end else if (k == 1) begin
        check("t4_pc_0000", cmd_pc2, 16'h0000);
        check("t4_cmd_0000", command2, 16'h0000);
      end
    end

    // Back-pressure: queue fills and requests stop
    cmd_ready = 1'b0;
    step();
    check("t2_req_full", imem_req, 0);
    check("t2_cmd_hold", command, 16'hC003);
    step();
    check("t2_req_full2", imem_req, 0);
    check("t2_cmd_hold2", command, 16'hC003);
    check("t2_pc_hold2", cmd_pc, 3);
    check("t2_addr_hold", imem_addr, 5);
    cmd_ready = 1'b1;
    step();
    check("t2_cmd_next", command, 16'hC004);
    check("t2_pc_next", cmd_pc, 4);
    check("t2_req_again", imem_req, 1);
    check("t2_addr5", imem_addr, 5);

    // Redirect in the same cycle that address 5 is acked
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    check("t3_valid", cmd_valid, 0);
    check("t3_addr", imem_addr, 16'h0040);
    check("t3_req", imem_req, 1);
    step();
    check("t3_valid2", cmd_valid, 1);
    check("t3_pc", cmd_pc, 16'h0040);
    check("t3_cmd", command, 16'hC040);

    // Reset mid-operation with a queued word and a pending request
    cmd_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_valid", cmd_valid, 0);
    check("t5_req", imem_req, 0);
    check("t5_addr", imem_addr, 0);
    cmd_ready = 1'b1;
    hlt_mem = 1'b1;
    step();
    check("t5_addr_rst", imem_addr, 0);
    check("t5_valid2", cmd_valid, 0);
    check("t5_req2", imem_req, 1);

    // Restart, then HLT word at address 3
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_cmd_s", command, 16'hC000 | 16'(k));
      check("t6_addr_s", imem_addr, k + 1);
    end
    step();
    check("t6_cmd_hlt", command, 16'hC0F0);
    check("t6_pc_hlt", cmd_pc, 3);
    check("t6_halted", fetch_halted, HaltEn);
    check("t6_req", imem_req, !HaltEn);
    check("t6_addr4", imem_addr, 4);
    step();
    check("t6_valid_after", cmd_valid, !HaltEn);
    check("t6_req_after", imem_req, !HaltEn);
    check("t6_addr_after", imem_addr, HaltEn ? 32'd4 : 32'd5);
    check("t6_halted_hold", fetch_halted, HaltEn);

    redirect = 1'b1; redirect_pc = 16'h0010;
    step();
    redirect = 1'b0;
    check("t6_unhalt", fetch_halted, 0);
    check("t6_addr_redir", imem_addr, 16'h0010);
    check("t6_req_redir", imem_req, 1);
    check("t6_valid_redir", cmd_valid, 0);
    step();
    check("t6_cmd_resume", command, 16'hC010);
    check("t6_pc_resume", cmd_pc, 16'h0010);
    check("t6_addr_resume", imem_addr, 16'h0011);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch and issue block for the 16-bit core. It is the producer side of the 16-bit command interface that feeds the decode unit. It maintains the fetch PC, reads instruction words from instruction memory over a valid/ack handshake, and buffers them in a small prefetch queue. Each word is presented to decode with its PC. Branch/jump redirects flush the queue and restart fetch.

Parameters:
ADDR_W, 16, instruction address width (word-addressed)
QDEPTH, 2, prefetch queue depth; power of 2, minimum 2
RESET_PC, 0, fetch PC loaded on reset

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  fetch address (= fetch PC)
imem_ack  in  1  memory accepts request and returns data this cycle
imem_rdata  in  16  instruction word, valid when imem_req && imem_ack
cmd_valid  out  1  command word available to decode
command  out  16  instruction word at queue head
cmd_pc  out  ADDR_W  address of command
cmd_ready  in  1  decode/execute consumes command this cycle
redirect  in  1  PC load (taken branch/jump)
redirect_pc  in  ADDR_W  new fetch target
fetch_halted  out  1  fetch stopped by HLT (optional feature)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: fpc=RESET_PC, queue count=0, run=0, halted=0.
- Reset values (outputs): imem_req=0, cmd_valid=0, command=16'h0000, cmd_pc=0, fetch_halted=0.
- run flag: cleared by reset, set 1 in the first cycle after reset deasserts.
- imem_req = run && (count < QDEPTH) && !halted. imem_addr = fpc at all times.
- Transfer occurs only when imem_req && imem_ack in the same cycle. The memory must not assume commitment before ack; address may change between cycles without ack.
- On transfer: push {imem_rdata, fpc} to queue tail; fpc <= fpc + 1, wrapping 2^ADDR_W-1 to 0.
- cmd_valid = (count != 0); command/cmd_pc = head entry, held stable while cmd_valid && !cmd_ready.
- Pop on cmd_valid && cmd_ready.
- Simultaneous push and pop: count unchanged, order preserved.
- Full queue: imem_req low; no overflow is possible. Empty queue: cmd_valid low; pop ignored.
- Redirect priority, same cycle: redirect > transfer > pop.
- On redirect: queue flushed (count=0, pointers reset); fpc <= redirect_pc; any transfer in that cycle is discarded and does not increment fpc; halted cleared.
- Latency: with a combinational ack, a word requested in cycle N appears on command in cycle N+1. After a redirect in cycle N, the first request to redirect_pc occurs in N+1 and the command is valid at the earliest in N+2.
- Reset mid-operation: queue contents and pending request are abandoned; no command issued in the cycle after reset; fetch resumes at RESET_PC.
- Sustained throughput: 1 word/cycle when ack is always high and cmd_ready is always high.

Optional Feature:
HALT_DETECT_EN
- Defined: a pushed word with [15:14]=2'b11 and [7:4]=4'b1111 (HLT) sets halted. The HLT word itself is queued and issued normally. No further requests are made. fetch_halted=halted. Cleared only by redirect or reset.
- Undefined: no decoding of fetched words; halted held 0; fetch_halted tied 0; fetch continues indefinitely.

Test Plan:
1. Release reset; memory acks every cycle with rdata=16'hC000|addr, cmd_ready=1 -> addresses 0,1,2,… requested. Commands C000, C001, C002 appear with cmd_pc 0,1,2, one per cycle from the second cycle after release.
2. Hold cmd_ready=0 -> after 2 transfers imem_req=0, count=2, command stays C000. Raise cmd_ready -> C000, C001, C002 issued in order, no loss or duplication.
3. Redirect with redirect_pc=16'h0040 in the same cycle that addr 5 is acked -> word 5 is never issued. cmd_valid=0 next cycle, imem_addr=0x0040, and the next command has cmd_pc=0x0040.
4. RESET_PC=16'hFFFF -> requests FFFF then 0000; cmd_pc sequence FFFF, 0000.
5. Assert reset with queue full and imem_req high -> next cycle cmd_valid=0, imem_req=0. Two cycles after release, imem_addr=RESET_PC with queue empty.
6. With HALT_DETECT_EN defined, word at addr 3 = 16'hC0F0 -> no request beyond addr 3, C0F0 issued, fetch_halted=1. Redirect to 16'h0010 -> fetch_halted=0 and fetch resumes at 0x0010.
